// File: rtl/cfu_pkg.sv
// Shared decode constants and FSM state type for the multi-op MAC custom function unit.
package cfu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SADD  = 3'b001;
    localparam logic [2:0] OP_MAC   = 3'b010;
    localparam logic [2:0] OP_RDACC = 3'b011;
    localparam logic [2:0] OP_LDACC = 3'b100;

    localparam int F7_UNS = 0;
    localparam int F7_HI  = 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

endpackage

// File: rtl/cfu_mac_lane.sv
// One LANE_W x LANE_W multiplier, signed or unsigned, result extended to ACC_W.
module cfu_mac_lane #(
    parameter int LANE_W = 8,
    parameter int ACC_W  = 48
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              uns,
    output logic [ACC_W-1:0]  prod
);
    localparam int PW = 2 * LANE_W;

    logic signed [PW+1:0] ax, bx, px;

    assign ax = $signed({{(LANE_W+2){a[LANE_W-1] & ~uns}}, a});
    assign bx = $signed({{(LANE_W+2){b[LANE_W-1] & ~uns}}, b});
    assign px = ax * bx;

    // An unsigned product is non-negative, so sign-extending px covers both modes.
    assign prod = ACC_W'(px);

endmodule

// File: rtl/cfu_mac.sv
// EX-stage custom function unit: 32-bit add, lane-wise add, iterative lane MAC and accumulator access.
import cfu_pkg::*;

module cfu_mac #(
    parameter int LANE_W = 8,
    parameter int ACC_W  = 48
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic        stall_o,
    output logic [31:0] rslt_o
);
    localparam int LANES = 32 / LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                         state, state_nx;
    logic [CNT_W-1:0]               cnt;
    logic [2:0]                     op_q;
    logic [1:0]                     f7_q;
    logic [31:0]                    a_q, b_q, rslt_q;
    logic [ACC_W-1:0]               acc, prod, acc_sum;
    logic [63:0]                    acc_sx;
    logic [LANES-1:0][LANE_W-1:0]   a_l, b_l, sadd_l;
    logic                           op_def, accept, mac_last;

    assign a_l = a_q;
    assign b_l = b_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_sadd
            assign sadd_l[gi] = a_l[gi] + b_l[gi];
        end
    endgenerate

    cfu_mac_lane #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_lane (
        .a    (a_l[cnt]),
        .b    (b_l[cnt]),
        .uns  (f7_q[F7_UNS]),
        .prod (prod)
    );

    assign acc_sum  = acc + prod;
    assign acc_sx   = 64'($signed(acc));
    assign mac_last = (cnt == CNT_W'(LANES - 1));

    // Undefined opcodes never leave IDLE/DONE and never stall.
    assign op_def  = (funct3_i <= OP_LDACC);
    assign accept  = en_i & op_def & (state != EXEC) & ~rst_i;
    assign stall_o = ~rst_i & (accept | (state == EXEC));
    assign rslt_o  = (~rst_i && state == DONE) ? rslt_q : 32'd0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = accept ? EXEC : IDLE;
            EXEC:       if (op_q != OP_MAC || mac_last) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            rslt_q <= '0;
            op_q   <= '0;
            f7_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= funct3_i;
                f7_q <= funct7_i[1:0];
                a_q  <= src1_i;
                b_q  <= src2_i;
                cnt  <= '0;
            end
            if (state == EXEC) begin
                case (op_q)
                    OP_ADD:   rslt_q <= a_q + b_q;
                    OP_SADD:  rslt_q <= sadd_l;
                    OP_MAC: begin
                        acc <= acc_sum;
                        cnt <= cnt + 1'b1;
                        if (mac_last) rslt_q <= acc_sum[31:0];
                    end
                    OP_RDACC: rslt_q <= f7_q[F7_HI] ? acc_sx[63:32] : acc[31:0];
                    OP_LDACC: begin
                        rslt_q <= acc[31:0];
                        acc    <= ACC_W'($signed(a_q));
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfu_mac.sv
// Scoreboard bench for cfu_mac (LANE_W=8, ACC_W=48): expected results are queued with their due cycle.
module tb_cfu_mac;
    import cfu_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [2:0]  f3 = '0;
    logic [6:0]  f7 = '0;
    logic [31:0] s1 = '0, s2 = '0;
    logic        stall;
    logic [31:0] rslt;

    cfu_mac #(.LANE_W(8), .ACC_W(48)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .funct3_i(f3), .funct7_i(f7),
        .src1_i(s1), .src2_i(s2), .stall_o(stall), .rslt_o(rslt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0, n_chk = 0, n_fail = 0;
    logic [47:0] acc_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] ev);
        n_chk++;
        if (act !== ev) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, ev);
        end
    endtask

    // rslt_o must carry the queued value in its due cycle and zero everywhere else.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            chk("rslt", rslt, sb[0].val);
            void'(sb.pop_front());
        end else begin
            chk("rslt_zero", rslt, 32'd0);
        end
    end

    function automatic logic [31:0] sadd_m(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
        return r;
    endfunction

    function automatic logic [47:0] mac_m(input logic [47:0] acc, input logic [31:0] a,
                                          input logic [31:0] b, input logic u);
        logic [47:0] r;
        int x, y;
        r = acc;
        for (int i = 0; i < 4; i++) begin
            x = u ? int'(a[8*i +: 8]) : int'($signed(a[8*i +: 8]));
            y = u ? int'(b[8*i +: 8]) : int'($signed(b[8*i +: 8]));
            r = r + 48'(longint'(x) * longint'(y));
        end
        return r;
    endfunction

    // Drives one issue at the current negedge; en stays high until nxt.
    task automatic drive(input logic [2:0] op, input logic [6:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ev, input int lat,
                         input logic exp_stall, input logic push);
        en = 1'b1; f3 = op; f7 = m; s1 = a; s2 = b;
        if (push) sb.push_back('{due: cyc + lat, val: ev});
        #1;
        chk("stall_issue", {31'd0, stall}, {31'd0, exp_stall});
    endtask

    task automatic nxt();
        @(negedge clk);
        en = 1'b0;
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic [6:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ev, input int lat);
        @(negedge clk);
        drive(op, m, a, b, ev, lat, 1'b1, 1'b1);
        for (int k = 1; k < lat; k++) begin
            nxt();
            chk("stall_busy", {31'd0, stall}, 32'd1);
        end
        nxt();
        chk("stall_end", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, ev;

        // en_i during reset is ignored and never stalls
        repeat (2) @(negedge clk);
        drive(OP_ADD, 7'd0, 32'd1, 32'd2, 32'd0, 2, 1'b0, 1'b0);
        nxt();
        chk("stall_rst", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(OP_ADD,  7'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 2);
        run(OP_SADD, 7'd0, 32'h01FF_7F80, 32'h0101_0101, 32'h0200_8081, 2);

        run(OP_LDACC, 7'd0, 32'd0, 32'd0, 32'd0, 2);
        run(OP_MAC,   7'd0, 32'hFF02_0380, 32'h0102_0304, 32'hFFFF_FE0C, 5);
        run(OP_RDACC, 7'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 2);
        run(OP_LDACC, 7'd0, 32'd0, 32'd0, 32'hFFFF_FE0C, 2);
        run(OP_MAC,   7'd1, 32'hFF02_0380, 32'h0102_0304, 32'h0000_030C, 5);

        // back-to-back RDACC in MAC's DONE cycle; stray en mid-EXEC must be ignored
        run(OP_LDACC, 7'd0, 32'd0, 32'd0, 32'h0000_030C, 2);
        @(negedge clk);
        drive(OP_MAC, 7'd0, 32'hFF02_0380, 32'h0102_0304, 32'hFFFF_FE0C, 5, 1'b1, 1'b1);
        nxt();
        chk("stall_busy", {31'd0, stall}, 32'd1);
        @(negedge clk);
        drive(OP_ADD, 7'd0, 32'h1, 32'h1, 32'd0, 0, 1'b1, 1'b0);
        nxt();
        chk("stall_busy", {31'd0, stall}, 32'd1);
        nxt();
        chk("stall_busy", {31'd0, stall}, 32'd1);
        @(negedge clk);
        drive(OP_RDACC, 7'd0, 32'd0, 32'd0, 32'hFFFF_FE0C, 2, 1'b1, 1'b1);
        nxt();
        chk("stall_busy", {31'd0, stall}, 32'd1);
        nxt();
        chk("stall_end", {31'd0, stall}, 32'd0);
        run(OP_RDACC, 7'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 2);

        // reset in the middle of a MAC abandons it
        run(OP_LDACC, 7'd0, 32'h1234_5678, 32'd0, 32'hFFFF_FE0C, 2);
        @(negedge clk);
        drive(OP_MAC, 7'd0, 32'hFF02_0380, 32'h0102_0304, 32'd0, 5, 1'b1, 1'b1);
        nxt();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("stall_in_rst", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("stall_after_rst", {31'd0, stall}, 32'd0);
        run(OP_RDACC, 7'd0, 32'd0, 32'd0, 32'd0, 2);

        // undefined opcodes: no stall, no result, acc untouched
        run(OP_LDACC, 7'd0, 32'h0000_ABCD, 32'd0, 32'd0, 2);
        @(negedge clk);
        drive(3'b111, 7'd3, 32'hDEAD_BEEF, 32'h1, 32'd0, 0, 1'b0, 1'b0);
        nxt();
        chk("stall_undef", {31'd0, stall}, 32'd0);
        @(negedge clk);
        drive(3'b101, 7'd0, 32'hDEAD_BEEF, 32'h1, 32'd0, 0, 1'b0, 1'b0);
        nxt();
        chk("stall_undef", {31'd0, stall}, 32'd0);
        run(OP_RDACC, 7'd0, 32'd0, 32'd0, 32'h0000_ABCD, 2);
        acc_m = 48'h0000_0000_ABCD;

        // randomized traffic against the bench model
        ra = $urandom;
        run(OP_LDACC, 7'd0, ra, 32'd0, acc_m[31:0], 2);
        acc_m = 48'($signed(ra));
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            acc_m = mac_m(acc_m, ra, rb, i[0]);
            run(OP_MAC, {6'd0, i[0]}, ra, rb, acc_m[31:0], 5);
        end
        ev = 32'($signed(acc_m[47:32]));
        run(OP_RDACC, 7'd2, 32'd0, 32'd0, ev, 2);
        run(OP_RDACC, 7'd0, 32'd0, 32'd0, acc_m[31:0], 2);
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            run(OP_ADD,  7'd0, ra, rb, ra + rb, 2);
            run(OP_SADD, 7'd0, ra, rb, sadd_m(ra, rb), 2);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cfu_mac.md
# cfu_mac

Parametrised multi-op custom function unit with a lane-wise SIMD datapath and a persistent multiply-accumulate register. It sits in the core's EX stage on the CFU port (funct3/funct7 decode, two 32-bit sources, stall/result return) and replaces the single-op adder CFU. It adds packed arithmetic, an iterative one-lane-per-cycle MAC and accumulator read/load, all under one shared stall handshake.

## Interface
Parameters:
- `LANE_W`, default 8: lane width in bits; legal values are 8 and 16. `LANES = 32/LANE_W`.
- `ACC_W`, default 48: accumulator width; legal range is 33..64.

Ports:
- `clk_i`  in  1  the single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  1  one-cycle issue pulse from EX, sampled on the rising edge.
- `funct3_i`  in  3  operation select.
- `funct7_i`  in  7  modifier bits. Bit 0: unsigned MAC. Bit 1: read high accumulator word.
- `src1_i`  in  32  operand A; also the load value for LDACC.
- `src2_i`  in  32  operand B.
- `stall_o`  out  1  hold the pipeline.
- `rslt_o`  out  32  result; non-zero only in the DONE cycle.

## Operation
- Opcodes, selected by `funct3_i`:
  - 000 ADD: 32-bit add, wraps modulo 2^32.
  - 001 SADD: lane-wise add; each lane wraps independently, with no carry between lanes.
  - 010 MAC: acc += sum over lanes of lane(src1)×lane(src2). Each product is 2·LANE_W bits, sign-extended when `funct7_i[0]`=0 and zero-extended when it is 1, then extended to `ACC_W`. The accumulator wraps modulo 2^ACC_W. Result is the new `acc[31:0]`.
  - 011 RDACC: `funct7_i[1]`=0 returns `acc[31:0]`. `funct7_i[1]`=1 returns `acc[ACC_W-1:32]` sign-extended to 32 bits.
  - 100 LDACC: acc <= sign-extended `src1_i`; the result is the old `acc[31:0]`.
  - 101–111: no operation. No stall, `rslt_o`=0, acc unchanged, FSM stays IDLE.
- On an accepted `en_i`, latch opcode, funct7 and both operands. The datapath uses only the latched copies.
- FSM states:
  - IDLE → EXEC on `en_i` with a defined opcode. Clear the lane counter.
  - EXEC: ADD, SADD, RDACC and LDACC compute in one cycle and go to DONE. MAC processes lane k (from LSB) in its k-th EXEC cycle and goes to DONE after lane LANES-1.
  - DONE: present `rslt_o` and go to IDLE. An `en_i` arriving in DONE is accepted exactly as in IDLE (back-to-back issue).
- `en_i` during EXEC is ignored: no relatch, no restart.
- `stall_o` = (`en_i` & defined opcode & state∈{IDLE,DONE}) | (state==EXEC). It is combinational from `en_i`.
- `rslt_o` = latched result when state==DONE, else 0.
- Accumulator writes:
  - MAC updates acc once per lane cycle; partial values are not visible.
  - LDACC writes acc at its EXEC cycle.

## Timing
- Reset (`rst_i` high at an edge):
  - next state is IDLE; lane counter 0; acc 0; result register 0.
  - while `rst_i` is high, `stall_o`=0 and `rslt_o`=0, and `en_i` is ignored.
  - reset mid-MAC abandons the operation; no partial accumulate survives.
- Latency, counted from issue edge T:
  - ADD/SADD/RDACC/LDACC: `stall_o` high in cycles T and T+1; result valid in cycle T+2 with `stall_o` low.
  - MAC: `stall_o` high in cycles T..T+LANES; result in cycle T+LANES+1 (T+5 for LANE_W=8, T+3 for LANE_W=16).
- RDACC issued in the DONE cycle of a MAC sees the updated acc.

## Structure
- Package `cfu_pkg` holds:
  - opcode localparams (`OP_ADD`, `OP_SADD`, `OP_MAC`, `OP_RDACC`, `OP_LDACC`);
  - the funct7 bit indices;
  - the FSM state typedef (IDLE/EXEC/DONE).
- Sub-module `cfu_mac_lane` is a single-lane signed/unsigned LANE_W×LANE_W multiplier with extension to `ACC_W`. It is instantiated once and muxed by the lane counter.
- Top level `cfu_mac` contains decode, FSM, operand latches, accumulator and output mux.

## Test plan
All scenarios use LANE_W=8, ACC_W=48.
1. ADD `0x7FFFFFFF`+`0x00000001` → `stall_o` high for 2 cycles, `rslt_o`=`0x80000000` in cycle T+2, 0 before and after.
2. SADD `0x01FF7F80`+`0x01010101` → `0x02008081`. Checks per-lane wrap with no carry between lanes.
3. LDACC src1=0, then signed MAC `0xFF020380`×`0x01020304` → 5 stall cycles, result `0xFFFFFE0C` (−500).
   - Then RDACC with `funct7_i[1]`=1 → `0xFFFFFFFF`.
   - Repeat from LDACC 0 with `funct7_i[0]`=1 (unsigned) → `0x0000030C`.
4. Back-to-back: RDACC issued in the MAC's DONE cycle → returns the new acc. An `en_i` pulse mid-EXEC → ignored, latency unchanged.
5. `rst_i` asserted at T+2 of a MAC → next cycle `stall_o`=0, `rslt_o`=0; a following RDACC → 0.
6. funct3=111 with `en_i` → `stall_o`=0, `rslt_o`=0, acc unchanged (verified by a following RDACC).
